uart_receiver: RTL and testbench

Serial-to-parallel receive half of the UART link. It takes the asynchronous `rx` line, oversamples it at 16x the bit rate using a single-cycle `enb` tick, and validates start and stop bits. It presents each 8-bit, LSB-first frame on `data_out` with a sticky `rdy` flag and error flags. It sits between the pad and the host logic, and pairs with `uart_transmitter` on the far end, which emits 8N1 frames.

---
 rtl/uart_receiver.sv | 104 ++++++++++
 tb/tb_uart_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 16x oversampled, start/stop validated, LSB-first byte out
// with sticky ready, framing-error and overrun flags.
module uart_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t      state;
    logic        rx_meta;
    logic        rxs;
    logic [3:0]  scnt;
    logic [2:0]  bidx;
    logic [7:0]  shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            state     <= StIdle;
            scnt      <= 4'd0;
            bidx      <= 3'd0;
            shreg     <= 8'h00;
            data_out  <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;

            // Placed before the FSM so a coincident frame completion overrides the clear.
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end

            if (enb) begin
                case (state)
                    StIdle: begin
                        if (!rxs) begin
                            state <= StStart;
                            scnt  <= 4'd0;
                        end
                    end
                    StStart: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd7) begin
                            if (!rxs) begin
                                state <= StData;
                                scnt  <= 4'd0;
                                bidx  <= 3'd0;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                    StData: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            shreg[bidx] <= rxs;
                            if (bidx == 3'd7) begin
                                state <= StStop;
                                scnt  <= 4'd0;
                            end else begin
                                bidx <= bidx + 3'd1;
                            end
                        end
                    end
                    StStop: begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd15) begin
                            // Leaving at mid stop bit gives half a bit of slack for the next start.
                            state <= StIdle;
                            if (rxs) begin
                                data_out  <= shreg;
                                rdy       <= 1'b1;
                                frame_err <= 1'b0;
                                if (rdy) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: tick-offset reference model compared every cycle,
// directed test-plan scenarios with literal expectations, then randomized frames.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data_out  (data_out),
        .rdy       (rdy),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit running = 0;

    // Reference model: frame progress is tracked as an enb-tick offset from start detection.
    logic [7:0] m_data;
    logic       m_rdy, m_busy, m_ferr, m_ovr;
    logic [7:0] m_byte;
    logic       h1, h2;
    int         tcnt = 0;
    int         m_det = 0;
    bit         in_rst = 0;
    int         phase = 0;
    bit         clr_on_done = 0;
    int         clr_rate = 0;

    task automatic model_reset();
        m_data = 8'h00; m_rdy = 0; m_busy = 0; m_ferr = 0; m_ovr = 0;
        m_byte = 8'h00; h1 = 1; h2 = 1;
    endtask

    task automatic model_edge(input logic e, input logic c, input logic rx_v);
        logic r;
        logic rdy_pre;
        int   off;
        if (in_rst) begin
            model_reset();
        end else begin
            r = h2; h2 = h1; h1 = rx_v;
            rdy_pre = m_rdy;
            if (c) begin m_rdy = 0; m_ovr = 0; end
            if (e) begin
                tcnt++;
                if (!m_busy) begin
                    if (!r) begin m_busy = 1; m_det = tcnt; end
                end else begin
                    off = tcnt - m_det;
                    if (off == 8) begin
                        if (r) m_busy = 0;
                    end else if (off == 152) begin
                        m_busy = 0;
                        if (r) begin
                            if (rdy_pre) m_ovr = 1;
                            m_data = m_byte; m_rdy = 1; m_ferr = 0;
                        end else begin
                            m_ferr = 1;
                        end
                    end else if (off > 8 && off <= 136 && (off - 8) % 16 == 0) begin
                        m_byte[(off - 8) / 16 - 1] = r;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            checks++;
            if ({data_out, rdy, busy, frame_err, overrun} !==
                {m_data, m_rdy, m_busy, m_ferr, m_ovr}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: got data=%h rdy=%b busy=%b ferr=%b ovr=%b, want data=%h rdy=%b busy=%b ferr=%b ovr=%b",
                         $time, data_out, rdy, busy, frame_err, overrun,
                         m_data, m_rdy, m_busy, m_ferr, m_ovr);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    function automatic logic rnd_clr();
        return (clr_rate > 0) && (($urandom % clr_rate) == 0);
    endfunction

    // One clock: apply inputs now, advance the model across the following rising edge.
    task automatic cyc(input logic rx_v, input logic clr_v);
        logic e;
        logic c;
        e = (phase == 3);
        phase = (phase + 1) % 4;
        c = clr_v | (clr_on_done && e && m_busy && (tcnt + 1 - m_det) == 152);
        enb = e; rx = rx_v; rdy_clr = c;
        @(posedge clk);
        #1;
        model_edge(e, c, rx_v);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, rnd_clr());
    endtask

    // Entered at posedge+1; asserts reset between edges and releases it between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        in_rst = 1;
        model_reset();
        #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_rdy", {7'd0, rdy}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_ferr", {7'd0, frame_err}, 8'h00);
        chk("rst_ovr", {7'd0, overrun}, 8'h00);
        repeat (3) cyc(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        in_rst = 0;
    endtask

    // 16 ticks per bit, enb every 4 clocks: 64 clocks per bit. rst_at picks a bit to reset in.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rst_at);
        logic [9:0] bits;
        bit aborted;
        bits = {stop_v, b, 1'b0};
        aborted = 0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 64; k++) begin
                if (!aborted) begin
                    if (i == rst_at && k == 32) begin
                        do_reset();
                        aborted = 1;
                    end else begin
                        cyc(bits[i], rnd_clr());
                    end
                end
            end
        end
    endtask

    initial begin
        bit saw_busy;
        rst = 1'b1; rx = 1'b1; enb = 1'b0; rdy_clr = 1'b0;
        in_rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        running = 1;
        chk("init_data", data_out, 8'h00);
        chk("init_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h00);
        repeat (3) cyc(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        in_rst = 0;
        idle(20);

        // Nominal frame
        send_frame(8'hA5, 1'b1, -1);
        idle(60);
        chk("nom_data", data_out, 8'hA5);
        chk("nom_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h08);
        cyc(1'b1, 1'b1);
        chk("nom_clr_rdy", {7'd0, rdy}, 8'h00);
        idle(10);

        // Glitch rejection: low for 4 ticks
        saw_busy = 0;
        repeat (16) begin cyc(1'b0, 1'b0); saw_busy |= busy; end
        repeat (60) begin cyc(1'b1, 1'b0); saw_busy |= busy; end
        chk("glitch_busy_seen", {7'd0, saw_busy}, 8'h01);
        chk("glitch_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h00);
        chk("glitch_data", data_out, 8'hA5);

        // Framing error, then recovery
        send_frame(8'h3C, 1'b0, -1);
        idle(200);
        chk("ferr_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h02);
        chk("ferr_data", data_out, 8'hA5);
        send_frame(8'h81, 1'b1, -1);
        idle(60);
        chk("recov_data", data_out, 8'h81);
        chk("recov_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h08);
        cyc(1'b1, 1'b1);
        idle(10);

        // Overrun with back-to-back frames
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(60);
        chk("ovr_data", data_out, 8'h22);
        chk("ovr_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h09);
        cyc(1'b1, 1'b1);
        chk("ovr_clr", {4'd0, rdy, busy, frame_err, overrun}, 8'h00);
        idle(10);

        // Set/clear collision, first with rdy low, then with rdy already high
        clr_on_done = 1;
        send_frame(8'h66, 1'b1, -1);
        idle(60);
        clr_on_done = 0;
        chk("coll0_data", data_out, 8'h66);
        chk("coll0_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h08);
        clr_on_done = 1;
        send_frame(8'h99, 1'b1, -1);
        idle(60);
        clr_on_done = 0;
        chk("coll1_data", data_out, 8'h99);
        chk("coll1_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h09);

        // Reset in the middle of data bit 4
        send_frame(8'hFF, 1'b1, 5);
        idle(100);
        send_frame(8'h5A, 1'b1, -1);
        idle(60);
        chk("post_rst_data", data_out, 8'h5A);
        chk("post_rst_flags", {4'd0, rdy, busy, frame_err, overrun}, 8'h08);

        // Randomized traffic: bytes, bad stops, glitches, gaps, host clears
        clr_rate = 150;
        for (int n = 0; n < 40; n++) begin
            if (($urandom % 6) == 0) begin
                repeat ($urandom_range(60, 1)) cyc(1'b0, rnd_clr());
                idle($urandom_range(100, 40));
            end
            send_frame($urandom_range(255, 0), (($urandom % 8) != 0), -1);
            idle($urandom_range(80, 0));
        end
        clr_rate = 0;
        idle(200);

        running = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
